// File: rtl/sw_event_decoder.sv
// sw_event_decoder: synchronises and debounces two keys, emits press/long-press pulses,
// and turns them into a display-mode register and a capture-request handshake.
module sw_event_decoder #(
  parameter int DEBOUNCE_CYC = 800_000,
  parameter int LONG_CYC     = 40_000_000,
  parameter int MODE_NUM     = 4,
  parameter int MODE_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw1,
  input  logic              sw2,
  input  logic              capture_ack,
  output logic              sw1_press,
  output logic              sw2_press,
  output logic              sw1_long,
  output logic              sw2_long,
  output logic [MODE_W-1:0] mode,
  output logic              capture_req,
  output logic              ovf
);
  localparam logic [31:0]       DB_LAST   = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0]       LG_LAST   = 32'(LONG_CYC - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);
  typedef enum logic {IDLE, REQ} state_t;
  logic [1:0] w_sw, w_press, w_long;
  assign w_sw = {sw2, sw1};
  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic        r_s0, r_s1, r_db, r_db_d, r_press, r_long, r_fired;
    logic [31:0] r_dcnt, r_hold;
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_s0    <= 1'b0;
        r_s1    <= 1'b0;
        r_db    <= 1'b0;
        r_db_d  <= 1'b0;
        r_press <= 1'b0;
        r_long  <= 1'b0;
        r_fired <= 1'b0;
        r_dcnt  <= '0;
        r_hold  <= '0;
      end else begin
        r_s0    <= w_sw[g];
        r_s1    <= r_s0;
        r_dcnt  <= (r_s1 == r_db || r_dcnt == DB_LAST) ? '0 : r_dcnt + 32'd1;
        r_db    <= (r_s1 != r_db && r_dcnt == DB_LAST) ? r_s1 : r_db;
        r_db_d  <= r_db;
        r_press <= r_db & ~r_db_d;
        r_hold  <= !r_db ? '0 : (r_hold == LG_LAST) ? r_hold : r_hold + 32'd1;
        // r_fired blocks a repeat long pulse until the key is released
        r_long  <= r_db & ~r_fired & (r_hold == LG_LAST);
        r_fired <= r_db & (r_fired | (r_hold == LG_LAST));
      end
    end
    assign w_press[g] = r_press;
    assign w_long[g]  = r_long;
  end
  logic [MODE_W-1:0] r_mode;
  always_ff @(posedge clk) begin
    if (!rst) r_mode <= '0;
    else if (w_long[0]) r_mode <= '0;
    else if (w_press[0]) r_mode <= (r_mode == MODE_LAST) ? '0 : r_mode + MODE_W'(1);
  end
  state_t r_state, w_next;
  logic   r_ovf, w_ovf_set;
  // a press coinciding with an ack re-arms the request instead of being dropped
  always_comb begin
    w_next    = r_state;
    w_ovf_set = 1'b0;
    w_next    = (r_state == IDLE) ? (w_press[1] ? REQ : IDLE)
              : ((w_long[1] || (capture_ack && !w_press[1])) ? IDLE : REQ);
    w_ovf_set = (r_state == REQ) && w_press[1] && !capture_ack && !w_long[1];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ovf   <= r_ovf | w_ovf_set;
    end
  end
  assign sw1_press   = w_press[0];
  assign sw2_press   = w_press[1];
  assign sw1_long    = w_long[0];
  assign sw2_long    = w_long[1];
  assign mode        = r_mode;
  assign capture_req = (r_state == REQ);
  assign ovf         = r_ovf;
endmodule

// File: tb/tb_sw_event_decoder.sv
// tb_sw_event_decoder: directed checks of debounce, press/long events, mode and capture FSM
// on two instances (DEBOUNCE_CYC=4 and DEBOUNCE_CYC=1, both LONG_CYC=20).
module tb_sw_event_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_a, sw1_a, sw2_a, ack_a, p1_a, p2_a, l1_a, l2_a, req_a, ovf_a;
  logic       rst_b, sw1_b, sw2_b, ack_b, p1_b, p2_b, l1_b, l2_b, req_b, ovf_b;
  logic [1:0] mode_a, mode_b;
  logic [7:0] w_oa, w_ob;
  assign w_oa = {p1_a, p2_a, l1_a, l2_a, mode_a, req_a, ovf_a};
  assign w_ob = {p1_b, p2_b, l1_b, l2_b, mode_b, req_b, ovf_b};
  sw_event_decoder #(.DEBOUNCE_CYC(4), .LONG_CYC(20), .MODE_NUM(4), .MODE_W(2)) u_a (
    .clk(clk), .rst(rst_a), .sw1(sw1_a), .sw2(sw2_a), .capture_ack(ack_a),
    .sw1_press(p1_a), .sw2_press(p2_a), .sw1_long(l1_a), .sw2_long(l2_a),
    .mode(mode_a), .capture_req(req_a), .ovf(ovf_a));
  sw_event_decoder #(.DEBOUNCE_CYC(1), .LONG_CYC(20), .MODE_NUM(4), .MODE_W(2)) u_b (
    .clk(clk), .rst(rst_b), .sw1(sw1_b), .sw2(sw2_b), .capture_ack(ack_b),
    .sw1_press(p1_b), .sw2_press(p2_b), .sw1_long(l1_b), .sw2_long(l2_b),
    .mode(mode_b), .capture_req(req_b), .ovf(ovf_b));
  typedef struct packed {
    logic       sw1, sw2, ack, rst;
    logic       p1, p2, l1, l2;
    logic [1:0] mode;
    logic       req, ovf;
  } vec_t;
  vec_t tbl [0:26];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b want %b ({p1,p2,l1,l2,mode,req,ovf})", nm, row, act, exp);
    end
  endtask
  task automatic press1_seq(input string nm, input int hold, input int rows,
                            input logic [1:0] m0, input int lrow, input logic pr);
    logic [1:0] m1, m;
    m1 = pr ? ((m0 == 2'd3) ? 2'd0 : m0 + 2'd1) : m0;
    for (int i = 0; i < rows; i++) begin
      sw1_a = (i < hold);
      @(negedge clk);
      m = (i < 7) ? m0 : (lrow >= 0 && i > lrow) ? 2'd0 : m1;
      chk(nm, i, w_oa, {pr && i == 6, 1'b0, i == lrow, 1'b0, m, 2'b00});
    end
  endtask
  initial begin
    {rst_a, sw1_a, sw2_a, ack_a} = 4'b0000;
    {rst_b, sw1_b, sw2_b, ack_b} = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("reset_a", 0, w_oa, 8'h00);
    chk("reset_b", 0, w_ob, 8'h00);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    tbl = '{
      12'b1101_0000_0000, 12'b0001_0000_0000, 12'b0001_0000_0000, 12'b0001_1100_0000,
      12'b0001_0000_0110, 12'b0101_0000_0110, 12'b0001_0000_0110, 12'b0001_0000_0110,
      12'b0001_0100_0110, 12'b0001_0000_0111, 12'b0011_0000_0101, 12'b0001_0000_0101,
      12'b0000_0000_0000, 12'b0101_0000_0000, 12'b0001_0000_0000, 12'b0001_0000_0000,
      12'b0001_0100_0000, 12'b0001_0000_0010, 12'b0101_0000_0010, 12'b0001_0000_0010,
      12'b0001_0000_0010, 12'b0001_0100_0010, 12'b0011_0000_0010, 12'b0001_0000_0010,
      12'b0011_0000_0000, 12'b0011_0000_0000, 12'b0001_0000_0000};
    for (int i = 0; i < 27; i++) begin
      {sw1_b, sw2_b, ack_b, rst_b} = {tbl[i].sw1, tbl[i].sw2, tbl[i].ack, tbl[i].rst};
      @(negedge clk);
      chk("gen_pulse_tbl", i, w_ob,
          {tbl[i].p1, tbl[i].p2, tbl[i].l1, tbl[i].l2, tbl[i].mode, tbl[i].req, tbl[i].ovf});
    end
    {sw1_b, sw2_b, ack_b, rst_b} = 4'b0001;
    press1_seq("glitch3", 3, 12, 2'd0, -1, 1'b0);
    press1_seq("press4", 4, 12, 2'd0, -1, 1'b1);
    press1_seq("press_m2", 10, 18, 2'd1, -1, 1'b1);
    press1_seq("press_m3", 10, 18, 2'd2, -1, 1'b1);
    press1_seq("press_wrap", 10, 18, 2'd3, -1, 1'b1);
    press1_seq("long1", 30, 45, 2'd0, 25, 1'b1);
    press1_seq("press_pre_rst", 10, 18, 2'd0, -1, 1'b1);
    for (int i = 0; i < 55; i++) begin
      sw2_a = (i < 45);
      rst_a = (i != 10);
      @(negedge clk);
      chk("sw2_rst_long", i, w_oa,
          {1'b0, i == 6 || i == 17, 1'b0, i == 36, (i < 10) ? 2'd1 : 2'd0,
           (i >= 7 && i < 10) || (i >= 18 && i < 37), 1'b0});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_event_decoder.md
Name: sw_event_decoder

Overview:
Receiving end of the sw1/sw2 key-event interface in the OV7620 capture design, at the 40 MHz system clock. Accepts either physical push-buttons or the simulated key-pulse generator. Each channel is synchronised, debounced and reduced to press and long-press events. sw1 events drive a display-mode register; sw2 events drive a capture-request handshake toward the frame-capture logic.

Parameters:
DEBOUNCE_CYC, 800_000, consecutive stable cycles needed to accept a level change (20 ms @ 40 MHz); >=1; value 1 passes 1-cycle generator pulses
LONG_CYC, 40_000_000, cycles the debounced level must stay high before a long-press event (1 s); >=2
MODE_NUM, 4, number of display modes; 2..2^MODE_W
MODE_W, 2, width of mode output

Ports:
clk  in  1  system clock, 40 MHz
rst  in  1  synchronous reset, active-low
sw1  in  1  key 1 raw, asynchronous, active-high
sw2  in  1  key 2 raw, asynchronous, active-high
capture_ack  in  1  capture logic accepted request, 1-cycle pulse
sw1_press  out  1  1-cycle pulse on debounced rising edge of sw1
sw2_press  out  1  1-cycle pulse on debounced rising edge of sw2
sw1_long  out  1  1-cycle pulse after sw1 held LONG_CYC cycles
sw2_long  out  1  1-cycle pulse after sw2 held LONG_CYC cycles
mode  out  MODE_W  current display mode
capture_req  out  1  level; pending capture request
ovf  out  1  sticky; a sw2 press was dropped while a request was pending

Behaviour:
- Reset: all registers clear on a clk edge with rst=0. All outputs are 0, mode=0, FSM=IDLE, all counters 0, debounced levels 0. A key still held after reset is a fresh press after debounce.
- Sync, per channel: s0<=sw, s1<=s0.
- Debounce, per channel, 32-bit cnt:
  - s1==db -> cnt<=0.
  - Else if cnt==DEBOUNCE_CYC-1 -> db<=s1, cnt<=0.
  - Else cnt<=cnt+1.
  - Glitches shorter than DEBOUNCE_CYC are rejected.
- Edge detect:
  - press<=db & ~db_d, registered.
  - Latency: if sw is first sampled high at edge k, db rises at edge k+1+DEBOUNCE_CYC and press is high for the one cycle after edge k+2+DEBOUNCE_CYC.
  - Release generates no event.
- Long press, per channel, 32-bit hold counter:
  - Cleared while db=0.
  - Increments while db=1, saturating at LONG_CYC-1.
  - The long pulse fires once, in the cycle after the counter first reaches LONG_CYC-1 (exactly LONG_CYC cycles after db rose). No repeat until released and pressed again.
  - Short press and long press on one channel never coincide.
- Mode register:
  - sw1_press: mode<=(mode==MODE_NUM-1)?0:mode+1.
  - sw1_long: mode<=0.
  - Otherwise hold.
- Capture FSM, states IDLE and REQ:
  - IDLE: sw2_press -> REQ, capture_req=1. capture_ack is ignored.
  - REQ, capture_ack only: -> IDLE, capture_req=0.
  - REQ, sw2_press only: stay in REQ, ovf<=1 (press dropped).
  - REQ, capture_ack and sw2_press in the same cycle: stay in REQ, capture_req stays 1 (new request replaces the acked one), ovf unchanged.
  - REQ, sw2_long: -> IDLE, capture_req=0 (cancel). This wins over capture_ack in the same cycle.
  - capture_req is registered; it rises in the cycle after sw2_press.
- ovf: set only as above; cleared only by reset.
- sw1 and sw2 are fully independent. Simultaneous events on both channels are handled in the same cycle.

Test Plan:
- DEBOUNCE_CYC=4, LONG_CYC=20. sw1 high for 3 cycles then low -> no sw1_press; mode stays 0.
- DEBOUNCE_CYC=4. sw1 held high 10 cycles, first sampled at edge k -> sw1_press single pulse after edge k+6; mode 0->1; no sw1_long.
- DEBOUNCE_CYC=4, LONG_CYC=20. Four clean sw1 presses -> mode 1,2,3,0 (wrap). Then hold sw1 30 cycles -> one sw1_long exactly 20 cycles after db rise; mode=0.
- DEBOUNCE_CYC=1. Generator-style 1-cycle pulse on sw2 -> sw2_press 3 edges later; capture_req=1 next cycle. Second sw2 pulse before ack -> ovf=1, capture_req stays 1. capture_ack -> capture_req=0.
- State REQ, capture_ack coincident with sw2_press -> capture_req stays 1, ovf stays 0. Next ack -> capture_req=0.
- Hold sw2 (request pending), assert rst=0 for 1 cycle mid-hold -> all outputs 0. On release of reset with sw2 still high -> new sw2_press after DEBOUNCE_CYC+2 edges; capture_req=1 again.
